// File: rtl/controler_alu_if.sv
// ID/EX control bundle between the pipeline datapath and the controller/ALU.
// The controller/ALU takes the slave side; the datapath takes the master side.
interface controler_alu_if;
    logic [31:0] instr;
    logic        rsrtequ;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] alu_out;
    logic        wpcir;
    logic        branch;
    logic        jump;
    logic        jr;
    logic        jal;
    logic [1:0]  fwda;
    logic [1:0]  fwdb;
    logic [6:0]  dctl;
    logic [3:0]  aluc;
    logic [4:0]  ectl;
    logic [4:0]  edes;
    logic [2:0]  mctl;
    logic [4:0]  mdes;

    modport slave (
        input  instr, rsrtequ, ea, eb,
        output alu_out, wpcir, branch, jump, jr, jal, fwda, fwdb,
        output dctl, aluc, ectl, edes, mctl, mdes
    );

    modport master (
        output instr, rsrtequ, ea, eb,
        input  alu_out, wpcir, branch, jump, jr, jal, fwda, fwdb,
        input  dctl, aluc, ectl, edes, mctl, mdes
    );
endinterface

// File: rtl/controler_alu.sv
// Five-stage MIPS subset controller: ID decode, forwarding, load-use stall,
// ID/EX and EX/MEM control registers, and the EX-stage ALU.
module controler_alu (
    input  logic            clock,
    input  logic            resetn,
    controler_alu_if.slave  bus
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpXori  = 6'h0e;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnSra = 6'h03;
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnXor = 6'h26;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0100;
    localparam logic [3:0] AluAnd = 4'b0001;
    localparam logic [3:0] AluOr  = 4'b0101;
    localparam logic [3:0] AluXor = 4'b0010;
    localparam logic [3:0] AluLui = 4'b0110;
    localparam logic [3:0] AluSll = 4'b0011;
    localparam logic [3:0] AluSrl = 4'b0111;
    localparam logic [3:0] AluSra = 4'b1111;

    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign op   = bus.instr[31:26];
    assign rs   = bus.instr[25:21];
    assign rt   = bus.instr[20:16];
    assign rd   = bus.instr[15:11];
    assign func = bus.instr[5:0];

    // Shift amount field is not used: shifts take their count from ea.
    logic unused_shamt;
    assign unused_shamt = ^bus.instr[10:6];

    // Instruction one-hots
    logic rtype;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;

    assign rtype  = (op == OpRtype);
    assign i_add  = rtype && (func == FnAdd);
    assign i_sub  = rtype && (func == FnSub);
    assign i_and  = rtype && (func == FnAnd);
    assign i_or   = rtype && (func == FnOr);
    assign i_xor  = rtype && (func == FnXor);
    assign i_sll  = rtype && (func == FnSll);
    assign i_srl  = rtype && (func == FnSrl);
    assign i_sra  = rtype && (func == FnSra);
    assign i_jr   = rtype && (func == FnJr);
    assign i_addi = (op == OpAddi);
    assign i_andi = (op == OpAndi);
    assign i_ori  = (op == OpOri);
    assign i_xori = (op == OpXori);
    assign i_lw   = (op == OpLw);
    assign i_sw   = (op == OpSw);
    assign i_beq  = (op == OpBeq);
    assign i_bne  = (op == OpBne);
    assign i_lui  = (op == OpLui);
    assign i_j    = (op == OpJ);
    assign i_jal  = (op == OpJal);

    logic r_shift, r_logic_arith, r_alu, i_alu;
    assign r_shift       = i_sll | i_srl | i_sra;
    assign r_logic_arith = i_add | i_sub | i_and | i_or | i_xor;
    assign r_alu         = r_logic_arith | r_shift;
    assign i_alu         = i_addi | i_andi | i_ori | i_xori;

    // Pipeline registers
    logic [4:0] ectl_q, ectl_d;
    logic [4:0] edes_q, edes_d;
    logic [3:0] ealuc_q, ealuc_d;
    logic [2:0] mctl_q;
    logic [4:0] mdes_q;

    logic ewreg, em2reg, mwreg, mm2reg;
    assign ewreg  = ectl_q[4];
    assign em2reg = ectl_q[3];
    assign mwreg  = mctl_q[2];
    assign mm2reg = mctl_q[1];

    // Forwarding source for one ID operand; EX result wins over MEM.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       e_wr,
                                           input logic       e_ld,
                                           input logic [4:0] e_des,
                                           input logic       m_wr,
                                           input logic       m_ld,
                                           input logic [4:0] m_des);
        logic [1:0] sel;
        sel = 2'b00;
        if (e_wr && (e_des != 5'd0) && (e_des == src) && !e_ld) begin
            sel = 2'b01;
        end else if (m_wr && (m_des != 5'd0) && (m_des == src)) begin
            sel = m_ld ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    logic       uses_rs, uses_rt;
    logic       stall;
    logic       regrt, aluimm, shift, sext;
    logic       wreg, m2reg, wmem;
    logic [4:0] dest;
    logic [3:0] aluc_id;

    always_comb begin
        uses_rs = r_logic_arith | i_jr | i_alu | i_lw | i_sw | i_beq | i_bne;
        uses_rt = r_alu | i_sw | i_beq | i_bne;
        stall   = ewreg && em2reg && (edes_q != 5'd0) &&
                  (((edes_q == rs) && uses_rs) || ((edes_q == rt) && uses_rt));

        regrt  = i_alu | i_lw | i_lui;
        aluimm = i_alu | i_lw | i_sw | i_lui;
        shift  = r_shift;
        sext   = i_andi | i_ori | i_xori | i_lui;
        dest   = regrt ? rt : rd;

        // A stalled instruction becomes a bubble: no side effects reach EX.
        wreg  = (r_alu | i_alu | i_lw | i_lui) && (dest != 5'd0) && !stall;
        m2reg = i_lw && !stall;
        wmem  = i_sw && !stall;

        aluc_id = AluAdd;
        if (i_sub || i_beq || i_bne)   aluc_id = AluSub;
        else if (i_and || i_andi)      aluc_id = AluAnd;
        else if (i_or || i_ori)        aluc_id = AluOr;
        else if (i_xor || i_xori)      aluc_id = AluXor;
        else if (i_lui)                aluc_id = AluLui;
        else if (i_sll)                aluc_id = AluSll;
        else if (i_srl)                aluc_id = AluSrl;
        else if (i_sra)                aluc_id = AluSra;
    end

    always_comb begin
        bus.wpcir  = stall;
        bus.branch = ((i_beq && bus.rsrtequ) || (i_bne && !bus.rsrtequ) ||
                      i_j || i_jal || i_jr) && !stall;
        bus.jump   = i_j | i_jal;
        bus.jr     = i_jr;
        bus.jal    = i_jal && !stall;
        bus.dctl   = {wreg, m2reg, wmem, aluimm, shift, sext, regrt};
        bus.aluc   = aluc_id;
        bus.fwda   = fwd_sel(rs, ewreg, em2reg, edes_q, mwreg, mm2reg, mdes_q);
        bus.fwdb   = fwd_sel(rt, ewreg, em2reg, edes_q, mwreg, mm2reg, mdes_q);
        bus.ectl   = ectl_q;
        bus.edes   = edes_q;
        bus.mctl   = mctl_q;
        bus.mdes   = mdes_q;
    end

    assign ectl_d  = {wreg, m2reg, wmem, aluimm, shift};
    assign edes_d  = dest;
    assign ealuc_d = aluc_id;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ectl_q  <= 5'd0;
            edes_q  <= 5'd0;
            ealuc_q <= 4'd0;
            mctl_q  <= 3'd0;
            mdes_q  <= 5'd0;
        end else begin
            ectl_q  <= ectl_d;
            edes_q  <= edes_d;
            ealuc_q <= ealuc_d;
            mctl_q  <= ectl_q[4:2];
            mdes_q  <= edes_q;
        end
    end

    // EX-stage ALU
    always_comb begin
        bus.alu_out = 32'd0;
        case (ealuc_q)
            AluAdd:  bus.alu_out = bus.ea + bus.eb;
            AluSub:  bus.alu_out = bus.ea - bus.eb;
            AluAnd:  bus.alu_out = bus.ea & bus.eb;
            AluOr:   bus.alu_out = bus.ea | bus.eb;
            AluXor:  bus.alu_out = bus.ea ^ bus.eb;
            AluLui:  bus.alu_out = {bus.eb[15:0], 16'h0000};
            AluSll:  bus.alu_out = bus.eb << bus.ea[4:0];
            AluSrl:  bus.alu_out = bus.eb >> bus.ea[4:0];
            AluSra:  bus.alu_out = $unsigned($signed(bus.eb) >>> bus.ea[4:0]);
            default: bus.alu_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_controler_alu.sv
// Directed bench for controler_alu: decode, forwarding, stall, ALU and async reset.
module tb_controler_alu;

    logic clock;
    logic resetn;
    int   n_cmp = 0;
    int   n_bad = 0;

    controler_alu_if bif ();

    controler_alu dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn      = 1'b0;
        bif.instr   = 32'h0000_0000;
        bif.rsrtequ = 1'b0;
        bif.ea      = 32'd0;
        bif.eb      = 32'd0;
        #2;
        check("rst_ectl", bif.ectl, 5'd0);
        check("rst_edes", bif.edes, 5'd0);
        check("rst_mctl", bif.mctl, 3'd0);
        check("rst_mdes", bif.mdes, 5'd0);
        check("rst_wpcir", bif.wpcir, 1'b0);
        check("rst_dctl_nop", bif.dctl, 7'b0000100);
        tick();
        check("rst_hold_ectl", bif.ectl, 5'd0);

        // add $1,$2,$3
        #1;
        resetn    = 1'b1;
        bif.instr = 32'h0043_0820;
        #1;
        check("add_dctl", bif.dctl, 7'b1000000);
        check("add_aluc", bif.aluc, 4'b0000);
        check("add_fwda", bif.fwda, 2'b00);
        tick();
        check("add_ectl", bif.ectl, 5'b10000);
        check("add_edes", bif.edes, 5'd1);
        bif.ea = 32'd5;
        bif.eb = 32'd7;
        #1;
        check("add_alu", bif.alu_out, 32'd12);

        // lw $4,0($5) followed by add $6,$4,$4
        bif.instr = 32'h8CA4_0000;
        #1;
        check("lw_dctl", bif.dctl, 7'b1101001);
        tick();
        bif.instr = 32'h0084_3020;
        #1;
        check("lu_wpcir", bif.wpcir, 1'b1);
        check("lu_wreg", bif.dctl[6], 1'b0);
        check("lu_fwda", bif.fwda, 2'b00);
        tick();
        check("lu_bubble_ectl", bif.ectl, 5'd0);
        check("lu_mctl", bif.mctl, 3'b110);
        check("lu_mdes", bif.mdes, 5'd4);
        check("lu_wpcir_clr", bif.wpcir, 1'b0);
        check("lu_fwda_mem", bif.fwda, 2'b11);
        check("lu_fwdb_mem", bif.fwdb, 2'b11);
        check("lu_wreg_back", bif.dctl[6], 1'b1);

        // addi $2,$0,5 then sub $7,$2,$3
        bif.instr = 32'h2002_0005;
        #1;
        check("addi_dctl", bif.dctl, 7'b1001001);
        tick();
        check("addi_ectl", bif.ectl, 5'b10010);
        check("addi_edes", bif.edes, 5'd2);
        bif.instr = 32'h0043_3822;
        #1;
        check("sub_fwda_ex", bif.fwda, 2'b01);
        check("sub_fwdb", bif.fwdb, 2'b00);
        check("sub_aluc", bif.aluc, 4'b0100);
        tick();
        check("sub_mctl", bif.mctl, 3'b100);
        check("sub_mdes", bif.mdes, 5'd2);
        check("sub_fwda_mem", bif.fwda, 2'b10);
        bif.ea = 32'd20;
        bif.eb = 32'd7;
        #1;
        check("sub_alu", bif.alu_out, 32'd13);

        // Branches and jumps
        bif.instr   = 32'h1022_0003;
        bif.rsrtequ = 1'b1;
        #1;
        check("beq_taken", bif.branch, 1'b1);
        bif.instr = 32'h1422_0003;
        #1;
        check("bne_not_taken", bif.branch, 1'b0);
        bif.rsrtequ = 1'b0;
        #1;
        check("bne_taken", bif.branch, 1'b1);
        bif.instr = 32'h0C00_0010;
        #1;
        check("jal_branch", bif.branch, 1'b1);
        check("jal_jal", bif.jal, 1'b1);
        check("jal_jump", bif.jump, 1'b1);
        check("jal_no_wreg", bif.dctl[6], 1'b0);
        bif.instr = 32'h0800_0010;
        #1;
        check("j_jump", bif.jump, 1'b1);
        check("j_jal", bif.jal, 1'b0);
        bif.instr = 32'h03E0_0008;
        #1;
        check("jr_jr", bif.jr, 1'b1);
        check("jr_branch", bif.branch, 1'b1);
        bif.instr = 32'hFC00_0000;
        #1;
        check("bad_dctl", bif.dctl, 7'd0);
        check("bad_aluc", bif.aluc, 4'd0);
        check("bad_branch", bif.branch, 1'b0);
        bif.instr = 32'h3401_0001;
        #1;
        check("ori_dctl", bif.dctl, 7'b1001011);
        check("ori_aluc", bif.aluc, 4'b0101);

        // sra $1,$2 by ea
        bif.instr = 32'h0002_0803;
        #1;
        check("sra_aluc", bif.aluc, 4'b1111);
        check("sra_dctl", bif.dctl, 7'b1000100);
        tick();
        bif.ea = 32'd4;
        bif.eb = 32'h8000_0000;
        #1;
        check("sra_alu", bif.alu_out, 32'hF800_0000);

        // lui $1,0x1234
        bif.instr = 32'h3C01_1234;
        #1;
        check("lui_aluc", bif.aluc, 4'b0110);
        check("lui_dctl", bif.dctl, 7'b1001011);
        tick();
        check("lui_ectl", bif.ectl, 5'b10010);
        bif.eb = 32'h0000_1234;
        #1;
        check("lui_alu", bif.alu_out, 32'h1234_0000);

        // sll
        bif.instr = 32'h0002_0840;
        #1;
        check("sll_aluc", bif.aluc, 4'b0011);
        tick();
        bif.ea = 32'd4;
        bif.eb = 32'd1;
        #1;
        check("sll_alu", bif.alu_out, 32'h0000_0010);

        // addi $0 must not write
        bif.instr = 32'h2000_0005;
        #1;
        check("addi_r0_dctl", bif.dctl, 7'b0001001);

        // Asynchronous reset mid-cycle
        check("pre_rst_ectl", bif.ectl, 5'b10001);
        check("pre_rst_mctl", bif.mctl, 3'b100);
        resetn = 1'b0;
        #1;
        check("arst_ectl", bif.ectl, 5'd0);
        check("arst_mctl", bif.mctl, 3'd0);
        check("arst_edes", bif.edes, 5'd0);
        check("arst_mdes", bif.mdes, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/controler_alu.md
CONTROLER_ALU -- requirements
Module: controler_alu

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port instr, input, 32 bits: the MIPS instruction currently in ID.
REQ-004 The block SHALL have port rsrtequ, input, 1 bit: 1 when the forwarded rs and rt operands in ID are equal.
REQ-005 The block SHALL have ports ea and eb, input, 32 bits each: the ALU operands already muxed by the EX datapath.
REQ-006 The block SHALL have port alu_out, output, 32 bits: the combinational ALU result, computed using ealuc.
REQ-007 The block SHALL have port wpcir, output, 1 bit: load-use stall; 1 holds PC and IF/ID.
REQ-008 The block SHALL have port branch, output, 1 bit: 1 when PC takes the branch or jump target.
REQ-009 The block SHALL have ports jump, jr and jal, output, 1 bit each: 1 while instr is j/jal, jr, or jal respectively.
REQ-010 The block SHALL have ports fwda and fwdb, output, 2 bits each: rs and rt source select. 00 = register file, 01 = EX ALU, 10 = MEM ALU, 11 = MEM load data.
REQ-011 The block SHALL have port dctl, output, 7 bits: {wreg, m2reg, wmem, aluimm, shift, sext, regrt} decoded for ID.
REQ-012 The block SHALL have port aluc, output, 4 bits: the ID ALU operation code.
REQ-013 The block SHALL have port ectl, output, 5 bits: registered {ewreg, em2reg, ewmem, ealuimm, eshift}.
REQ-014 The block SHALL have port edes, output, 5 bits: registered EX destination register.
REQ-015 The block SHALL have port mctl, output, 3 bits: registered {mwreg, mm2reg, mwmem}.
REQ-016 The block SHALL have port mdes, output, 5 bits: registered MEM destination register.

Function
REQ-017 Decode SHALL cover these instructions:
- R-type funct: add 20h, sub 22h, and 24h, or 25h, xor 26h, sll 00h, srl 02h, sra 03h, jr 08h.
- Opcodes: addi 08h, andi 0Ch, ori 0Dh, xori 0Eh, lw 23h, sw 2Bh, beq 04h, bne 05h, lui 0Fh, j 02h, jal 03h.
- Any other encoding SHALL drive all controls to 0.
REQ-018 aluc SHALL be encoded as follows:
- add/addi/lw/sw: 0000
- sub/beq/bne: 0100
- and/andi: 0001
- or/ori: 0101
- xor/xori: 0010
- lui: 0110
- sll: 0011
- srl: 0111
- sra: 1111
REQ-019 ALU behaviour SHALL be:
- add/sub: 32-bit wrap, no overflow flag.
- Logic ops: bitwise on ea and eb.
- lui: {eb[15:0], 16'h0}.
- Shifts: eb shifted by ea[4:0]; sra fills with eb[31].
REQ-020 Register-write and ALU-source controls SHALL be:
- regrt = 1 for I-type ALU ops, lw and lui (destination = instr[20:16]); otherwise destination = instr[15:11].
- aluimm = 1 for I-type ALU ops, lw, sw and lui.
- shift = 1 for sll/srl/sra.
REQ-021 Memory and extension controls SHALL be:
- m2reg = 1 for lw; wmem = 1 for sw.
- sext = 1 selects zero-extension (andi/ori/xori/lui); sext = 0 selects sign-extension.
REQ-022 wreg SHALL be 1 for R-type ALU ops, I-type ALU ops, lw and lui, and SHALL be 0 when the destination is register 0. jal SHALL NOT assert wreg.
REQ-023 branch SHALL equal (beq AND rsrtequ) OR (bne AND NOT rsrtequ) OR j OR jal OR jr.
REQ-024 fwda SHALL be selected in priority order:
- 01 if ewreg, edes != 0, edes == rs and NOT em2reg;
- else 10 if mwreg, mdes != 0, mdes == rs and NOT mm2reg;
- else 11 if mwreg, mdes != 0, mdes == rs and mm2reg;
- else 00.
REQ-025 fwdb SHALL follow the same rule as fwda, using rt.
REQ-026 wpcir SHALL equal ewreg AND em2reg AND edes != 0 AND ((edes == rs AND instr uses rs) OR (edes == rt AND instr uses rt)). rt is used by R-type ops, sw, beq and bne.
REQ-027 While wpcir = 1, wreg, wmem, m2reg, branch and jal SHALL be forced to 0, inserting a bubble into EX.
REQ-028 On every rising clock edge the E-stage registers SHALL load from the ID decode: ectl, edes and the internal ealuc load ID wreg, m2reg, wmem, aluimm, shift, the destination register and aluc.
REQ-029 On the same edge, mctl and mdes SHALL load from ewreg/em2reg/ewmem and edes.
REQ-030 Decode, forwarding, stall and ALU outputs SHALL be purely combinational, with zero latency.

Reset
REQ-031 While resetn = 0, ectl, edes, ealuc, mctl and mdes SHALL clear to 0 asynchronously. The combinational outputs then reflect instr with all pipeline valid bits 0, so there is no forwarding and no stall.

Verification
REQ-032 instr=00430820 (add $1,$2,$3) with empty pipeline -> dctl wreg=1, regrt=0, aluc=0000. Next clock -> edes=1, ewreg=1. ea=5, eb=7 -> alu_out=12.
REQ-033 Load-use: lw $4,0($5) in EX, then instr = add $6,$4,$4 -> wpcir=1 and wreg=0. After the lw reaches MEM -> wpcir=0, fwda=fwdb=11.
REQ-034 ALU-ALU forwarding: EX holds a writer of $2 (not a load) and ID holds sub $7,$2,$3 -> fwda=01, fwdb=00. One cycle later with MEM writing $2 -> fwda=10.
REQ-035 beq with rsrtequ=1 -> branch=1. bne with rsrtequ=1 -> branch=0. jal -> branch=1, jal=1, jump=1.
REQ-036 sra with ealuc=1111, ea=4, eb=80000000h -> alu_out=F8000000h. lui with eb=1234h -> alu_out=12340000h.
REQ-037 Assert resetn=0 mid-stream with ectl nonzero -> ectl, mctl, edes and mdes become 0 immediately, without waiting for a clock edge.
